// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: four-stage parametrised floating-point add/subtract.
// Denormals flush to zero, round-to-nearest-even, canonical quiet NaN.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int N = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic         sub,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    output logic [N-1:0] out,
    output logic         flag_invalid,
    output logic         flag_overflow,
    output logic         flag_inexact
);

    localparam int W    = MAN_W + 3;
    localparam int F    = MAN_W + 4;
    localparam int XW   = EXP_W + $clog2(MAN_W + 5) + 1;
    localparam int EMAX = (1 << EXP_W) - 1;

    localparam logic [N-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic         sp;
        logic         inv;
        logic [N-1:0] spv;
    } spec_t;

    typedef struct packed {
        logic             v;
        spec_t            sp;
        logic             sx;
        logic             eop;
        logic [EXP_W-1:0] ex;
        logic [EXP_W-1:0] dif;
        logic [MAN_W:0]   mx;
        logic [MAN_W:0]   my;
    } s1_t;

    typedef struct packed {
        logic             v;
        spec_t            sp;
        logic             sx;
        logic             eop;
        logic [EXP_W-1:0] ex;
        logic [MAN_W:0]   mx;
        logic [W-1:0]     ya;
        logic             st;
    } s2_t;

    typedef struct packed {
        logic          v;
        spec_t         sp;
        logic          sign;
        logic          zero;
        logic          zinex;
        logic [XW-1:0] e;
        logic [F-1:0]  m;
    } s3_t;

    function automatic int lzc(input logic [F-1:0] v);
        int  n;
        logic done;
        n = 0;
        done = 1'b0;
        for (int i = F - 1; i >= 0; i--) begin
            if (v[i]) done = 1'b1;
            else if (!done) n++;
        end
        return n;
    endfunction

    // S1: unpack, classify, order by magnitude
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             za, zb, ia, ib, na, nb, swap;
    logic [N-2:0]     ma, mb;
    logic [MAN_W:0]   ga, gb;
    s1_t              s1_d, s1_q;

    always_comb begin
        sa   = a[N-1];
        sb   = b[N-1] ^ sub;
        ea   = a[N-2 -: EXP_W];
        eb   = b[N-2 -: EXP_W];
        fa   = a[MAN_W-1:0];
        fb   = b[MAN_W-1:0];
        za   = ea == '0;
        zb   = eb == '0;
        ia   = (&ea) && (fa == '0);
        ib   = (&eb) && (fb == '0);
        na   = (&ea) && (fa != '0);
        nb   = (&eb) && (fb != '0);
        ma   = za ? '0 : a[N-2:0];
        mb   = zb ? '0 : b[N-2:0];
        ga   = za ? '0 : {1'b1, fa};
        gb   = zb ? '0 : {1'b1, fb};
        swap = mb > ma;

        s1_d        = '0;
        s1_d.v      = in_valid;
        s1_d.sp.sp  = na | nb | ia | ib;
        s1_d.sp.inv = na | nb | (ia & ib & (sa != sb));
        s1_d.sp.spv = s1_d.sp.inv ? QNAN :
            {ia ? sa : sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        s1_d.sx     = swap ? sb : sa;
        s1_d.eop    = sa != sb;
        s1_d.ex     = swap ? eb : ea;
        s1_d.dif    = swap ? eb - ea : ea - eb;
        s1_d.mx     = swap ? gb : ga;
        s1_d.my     = swap ? ga : gb;
    end

    always_ff @(posedge clk) begin
        if (reset) s1_q <= '0;
        else       s1_q <= s1_d;
    end

    // S2: align the smaller significand, keep guard/round/sticky
    logic [2*W-1:0] sh;
    s2_t            s2_d, s2_q;

    always_comb begin
        sh       = {s1_q.my, 2'b00, {W{1'b0}}} >> s1_q.dif;
        s2_d     = '0;
        s2_d.v   = s1_q.v;
        s2_d.sp  = s1_q.sp;
        s2_d.sx  = s1_q.sx;
        s2_d.eop = s1_q.eop;
        s2_d.ex  = s1_q.ex;
        s2_d.mx  = s1_q.mx;
        if (32'(s1_q.dif) >= W) begin
            s2_d.ya = '0;
            s2_d.st = |s1_q.my;
        end else begin
            s2_d.ya = sh[2*W-1:W];
            s2_d.st = |sh[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) s2_q <= '0;
        else       s2_q <= s2_d;
    end

    // S3: add or subtract magnitudes, then normalise
    logic [F-1:0]  xe, ye, df;
    logic [F:0]    sm;
    logic [XW-1:0] exw;
    int            lz;
    s3_t           s3_d, s3_q;

    always_comb begin
        xe   = {s2_q.mx, 3'b000};
        ye   = {s2_q.ya, s2_q.st};
        exw  = {{(XW-EXP_W){1'b0}}, s2_q.ex};
        sm   = {1'b0, xe} + {1'b0, ye};
        df   = xe - ye;
        lz   = lzc(df);

        s3_d      = '0;
        s3_d.v    = s2_q.v;
        s3_d.sp   = s2_q.sp;
        s3_d.sign = s2_q.sx;
        if (!s2_q.eop) begin
            s3_d.zero = sm == '0;
            if (sm[F]) begin
                s3_d.m = {sm[F:2], sm[1] | sm[0]};
                s3_d.e = exw + XW'(1);
            end else begin
                s3_d.m = sm[F-1:0];
                s3_d.e = exw;
            end
        end else begin
            s3_d.zero = df == '0;
            s3_d.m    = df << lz;
            s3_d.e    = exw - XW'(lz);
        end
        // exact zero is +0 unless both inputs were -0 under addition
        if (s3_d.zero) begin
            s3_d.sign = s2_q.sx & ~s2_q.eop;
        end else if (s3_d.e[XW-1] || s3_d.e == '0) begin
            s3_d.zero  = 1'b1;
            s3_d.zinex = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) s3_q <= '0;
        else       s3_q <= s3_d;
    end

    // S4: round to nearest even, pack, select special result
    logic [F-1:0]     m4;
    logic [MAN_W+1:0] mr;
    logic [MAN_W-1:0] fr;
    logic [XW-1:0]    er;
    logic             rup, inx, ovf;
    logic             k_sp, k_z, k_o;
    logic [N-1:0]     o_d;
    logic [2:0]       f_d;

    always_comb begin
        m4   = s3_q.m;
        rup  = m4[2] & (m4[3] | m4[1] | m4[0]);
        inx  = |m4[2:0];
        mr   = {1'b0, m4[F-1:3]} + {{(MAN_W+1){1'b0}}, rup};
        er   = s3_q.e + {{(XW-1){1'b0}}, mr[MAN_W+1]};
        fr   = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
        ovf  = er >= XW'(EMAX);
        k_sp = s3_q.sp.sp;
        k_z  = ~k_sp & s3_q.zero;
        k_o  = ~k_sp & ~s3_q.zero & ovf;
        o_d  = '0;
        f_d  = '0;
        unique case (1'b1)
            k_sp: begin
                o_d = s3_q.sp.spv;
                f_d = {s3_q.sp.inv, 2'b00};
            end
            k_z: begin
                o_d = {s3_q.sign, {(N-1){1'b0}}};
                f_d = {2'b00, s3_q.zinex};
            end
            k_o: begin
                o_d = {s3_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                f_d = 3'b011;
            end
            default: begin
                o_d = {s3_q.sign, er[EXP_W-1:0], fr};
                f_d = {2'b00, inx};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out           <= '0;
            flag_invalid  <= 1'b0;
            flag_overflow <= 1'b0;
            flag_inexact  <= 1'b0;
        end else begin
            out_valid <= s3_q.v;
            if (s3_q.v) begin
                out <= o_d;
                {flag_invalid, flag_overflow, flag_inexact} <= f_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed and randomized checks of fp_addsub_pipe.
// Reference model uses exact wide-integer sums then rounds to nearest even.
module tb_fp_addsub_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, sub;
    logic [31:0] a, b;
    logic        out_valid;
    logic [31:0] out;
    logic        flag_invalid, flag_overflow, flag_inexact;
    logic [2:0]  flags;

    logic        h_in_valid, h_sub;
    logic [15:0] h_a, h_b;
    logic        h_out_valid;
    logic [15:0] h_out;
    logic        h_inv, h_ovf, h_inx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    assign flags = {flag_invalid, flag_overflow, flag_inexact};

    fp_addsub_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .sub(sub),
        .a(a), .b(b), .out_valid(out_valid), .out(out),
        .flag_invalid(flag_invalid), .flag_overflow(flag_overflow),
        .flag_inexact(flag_inexact)
    );

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .reset(reset), .in_valid(h_in_valid), .sub(h_sub),
        .a(h_a), .b(h_b), .out_valid(h_out_valid), .out(h_out),
        .flag_invalid(h_inv), .flag_overflow(h_ovf),
        .flag_inexact(h_inx)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] o;
        logic [2:0]  f;
    } vec_t;

    typedef struct packed {
        int          due;
        logic [31:0] o;
        logic [2:0]  f;
    } exp_t;

    localparam int WB = 320;

    // Exact value of each operand as an integer in units of 2^-149.
    function automatic void ref_add(input logic [31:0] x, input logic [31:0] y,
                                    input bit s, output logic [31:0] r,
                                    output logic [2:0] fl);
        bit sx, sy, nx, ny, ix, iy, rs;
        int ex, ey, p, e, sh;
        logic [WB-1:0] mx, my, mag, q, rem, half, one;
        sx = x[31];
        sy = y[31] ^ s;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        nx = (ex == 255) && (x[22:0] != 0);
        ny = (ey == 255) && (y[22:0] != 0);
        ix = (ex == 255) && (x[22:0] == 0);
        iy = (ey == 255) && (y[22:0] == 0);
        r = '0;
        fl = '0;
        if (nx || ny || (ix && iy && sx != sy)) begin
            r = 32'h7FC00000;
            fl = 3'b100;
            return;
        end
        if (ix) begin r = {sx, 8'hFF, 23'd0}; return; end
        if (iy) begin r = {sy, 8'hFF, 23'd0}; return; end
        one = 1;
        mx = '0;
        my = '0;
        if (ex != 0) mx = {{(WB-24){1'b0}}, 1'b1, x[22:0]} << (ex - 1);
        if (ey != 0) my = {{(WB-24){1'b0}}, 1'b1, y[22:0]} << (ey - 1);
        if (sx == sy) begin mag = mx + my; rs = sx; end
        else if (mx >= my) begin mag = mx - my; rs = sx; end
        else begin mag = my - mx; rs = sy; end
        if (mag == 0) begin
            r = {(sx == sy) ? sx : 1'b0, 31'd0};
            return;
        end
        p = 0;
        for (int i = 0; i < WB; i++) if (mag[i]) p = i;
        e = p - 22;
        if (e <= 0) begin r = {rs, 31'd0}; fl = 3'b001; return; end
        sh = p - 23;
        q = mag >> sh;
        rem = mag - (q << sh);
        half = (sh > 0) ? (one << (sh - 1)) : '0;
        if (sh > 0 && (rem > half || (rem == half && q[0]))) q = q + 1;
        if (rem != 0) fl[0] = 1'b1;
        if (q[24]) begin q = q >> 1; e++; end
        if (e >= 255) begin r = {rs, 8'hFF, 23'd0}; fl = 3'b011; return; end
        r = {rs, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op(input logic [31:0] rf);
        logic [7:0]  e;
        logic [22:0] f;
        logic        s;
        s = 1'($urandom);
        f = 23'($urandom);
        case ($urandom_range(0, 11))
            0: e = 8'd0;
            1: begin
                e = 8'hFF;
                if ($urandom_range(0, 1) == 0) f = '0;
            end
            2: e = 8'hFE;
            3, 4, 5: begin
                e = rf[30:23] + 8'($urandom_range(0, 4)) - 8'd2;
                f = rf[22:0] ^ 23'($urandom_range(0, 15));
            end
            6: e = 8'd1;
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {s, e, f};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input bit v, input bit s,
                         input logic [31:0] x, input logic [31:0] y);
        in_valid = v;
        sub = s;
        a = x;
        b = y;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(0, 0, '0, '0);
        h_in_valid = 1'b0;
        h_sub = 1'b0;
        h_a = '0;
        h_b = '0;
        repeat (3) tick;
        reset = 1'b0;
        tick;
        checks++;
        if (out_valid !== 1'b0 || out !== 32'h0 || flags !== 3'b000) begin
            errors++;
            $display("FAIL reset: valid=%b out=%h flags=%b, want 0 0 000",
                     out_valid, out, flags);
        end
    endtask

    task automatic test_directed;
        vec_t t[$];
        t.push_back('{32'h40700000, 32'h40C80000, 1'b0, 32'h41200000, 3'b000});
        t.push_back('{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001});
        t.push_back('{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001});
        t.push_back('{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100});
        t.push_back('{32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100});
        t.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011});
        t.push_back('{32'h40490FDB, 32'h40490FDB, 1'b1, 32'h00000000, 3'b000});
        t.push_back('{32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 3'b000});
        t.push_back('{32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 3'b000});
        t.push_back('{32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 3'b000});
        t.push_back('{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000});
        t.push_back('{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001});
        t.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000});
        t.push_back('{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000});
        foreach (t[i]) begin
            drive(1, t[i].s, t[i].a, t[i].b);
            tick;
            drive(0, 0, '0, '0);
            tick;
            tick;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d early: valid=%b want 0", i, out_valid);
            end
            tick;
            checks++;
            if (out_valid !== 1'b1 || out !== t[i].o || flags !== t[i].f) begin
                errors++;
                $display("FAIL dir%0d: valid=%b out=%h flags=%b, want 1 %h %b",
                         i, out_valid, out, flags, t[i].o, t[i].f);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] w[3];
        w[0] = 32'h43188000;
        w[1] = 32'h40880000;
        w[2] = 32'hC0200000;
        drive(1, 0, 32'h43160000, 32'h40200000);
        tick;
        drive(1, 0, 32'h40080000, 32'h40080000);
        tick;
        drive(1, 1, 32'h40700000, 32'h40C80000);
        tick;
        drive(0, 0, '0, '0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b early: valid=%b want 0", out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (out_valid !== 1'b1 || out !== w[i] || flags !== 3'b000) begin
                errors++;
                $display("FAIL b2b%0d: valid=%b out=%h flags=%b, want 1 %h 000",
                         i, out_valid, out, flags, w[i]);
            end
        end
        tick;
        checks++;
        if (out_valid !== 1'b0 || out !== w[2]) begin
            errors++;
            $display("FAIL b2b hold: valid=%b out=%h, want 0 %h",
                     out_valid, out, w[2]);
        end
    endtask

    task automatic test_reset_mid;
        drive(1, 0, 32'h40700000, 32'h40C80000);
        tick;
        reset = 1'b1;
        drive(1, 1, 32'h40700000, 32'h40C80000);
        tick;
        drive(1, 0, 32'h3F800000, 32'h3F800000);
        tick;
        reset = 1'b0;
        drive(0, 0, '0, '0);
        checks++;
        if (out !== 32'h0 || flags !== 3'b000) begin
            errors++;
            $display("FAIL rst_clear: out=%h flags=%b, want 0 000", out, flags);
        end
        for (int i = 0; i < 6; i++) begin
            tick;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_flush%0d: valid=%b want 0", i, out_valid);
            end
        end
        drive(1, 0, 32'h40080000, 32'h40080000);
        for (int t = 1; t <= 5; t++) begin
            tick;
            drive(0, 0, '0, '0);
            checks++;
            if (out_valid !== (t == 4)) begin
                errors++;
                $display("FAIL rst_after t%0d: valid=%b want %b",
                         t, out_valid, (t == 4));
            end
            if (t == 4) begin
                checks++;
                if (out !== 32'h40880000) begin
                    errors++;
                    $display("FAIL rst_after out: %h want 40880000", out);
                end
            end
        end
    endtask

    task automatic test_half;
        logic [15:0] ha[4], hb[4], ho[4];
        logic        hs[4];
        logic [2:0]  hf[4];
        ha[0] = 16'h3C00; hb[0] = 16'h3C00; hs[0] = 0; ho[0] = 16'h4000; hf[0] = 3'b000;
        ha[1] = 16'h7BFF; hb[1] = 16'h7BFF; hs[1] = 0; ho[1] = 16'h7C00; hf[1] = 3'b011;
        ha[2] = 16'h3C00; hb[2] = 16'h3C00; hs[2] = 1; ho[2] = 16'h0000; hf[2] = 3'b000;
        ha[3] = 16'h7D00; hb[3] = 16'h3C00; hs[3] = 0; ho[3] = 16'h7E00; hf[3] = 3'b100;
        for (int i = 0; i < 4; i++) begin
            h_in_valid = 1'b1;
            h_sub = hs[i];
            h_a = ha[i];
            h_b = hb[i];
            tick;
            h_in_valid = 1'b0;
            repeat (3) tick;
            checks++;
            if (h_out_valid !== 1'b1 || h_out !== ho[i] ||
                {h_inv, h_ovf, h_inx} !== hf[i]) begin
                errors++;
                $display("FAIL half%0d: valid=%b out=%h flags=%b, want 1 %h %b",
                         i, h_out_valid, h_out, {h_inv, h_ovf, h_inx}, ho[i], hf[i]);
            end
        end
    endtask

    task automatic test_random;
        exp_t        sb[$];
        exp_t        e;
        logic [31:0] x, y, r;
        logic [2:0]  fl;
        bit          s;
        for (int i = 0; i < 700; i++) begin
            if (i < 690 && $urandom_range(0, 3) != 0) begin
                x = rnd_op(32'($urandom));
                y = rnd_op(x);
                s = 1'($urandom);
                ref_add(x, y, s, r, fl);
                e.due = cyc + 4;
                e.o = r;
                e.f = fl;
                sb.push_back(e);
                drive(1, s, x, y);
            end else begin
                drive(0, 0, 32'($urandom), 32'($urandom));
            end
            tick;
            checks++;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                if (out_valid !== 1'b1 || out !== sb[0].o || flags !== sb[0].f) begin
                    errors++;
                    $display("FAIL rand cyc%0d: valid=%b out=%h flags=%b, want 1 %h %b",
                             cyc, out_valid, out, flags, sb[0].o, sb[0].f);
                end
                void'(sb.pop_front());
            end else if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rand cyc%0d: unexpected valid=%b", cyc, out_valid);
            end
        end
        drive(0, 0, '0, '0);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rand drain: %0d results outstanding, want 0", sb.size());
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_reset_mid;
        test_half;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
